// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared types and constants for the segment display arbiter
package seg_disp_pkg;

  localparam int NUM_SRC  = 4;
  localparam int SRC_W    = 2;
  localparam int VALUE_W  = 20;
  localparam int MODE_W   = 4;
  localparam int CURSOR_W = 3;

  // Cursor position the display controller treats as "no cursor DP".
  localparam logic [CURSOR_W-1:0] CURSOR_NONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/seg_prio_enc.sv
// rtl/seg_prio_enc.sv - 4-bit fixed-priority encoder, bit 0 wins
module seg_prio_enc (
  input  logic [3:0] req,
  output logic       any,
  output logic [1:0] idx
);

  // Lowest set bit wins; idx is 0 when nothing is requested.
  always_comb begin
    any = |req;
    idx = 2'd0;
    if (req[0]) begin
      idx = 2'd0;
    end else if (req[1]) begin
      idx = 2'd1;
    end else if (req[2]) begin
      idx = 2'd2;
    end else if (req[3]) begin
      idx = 2'd3;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - shares the 4-digit display between base readout and transient requesters
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 150_000_000,
  parameter int unsigned GAP_CYCLES  = 10_000_000,
  parameter int unsigned CNT_W       = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [VALUE_W-1:0]           base_value,
  input  logic [MODE_W-1:0]            base_mode,
  input  logic [CURSOR_W-1:0]          base_cursor,
  input  logic [NUM_SRC-1:0]           req,
  input  logic [NUM_SRC*VALUE_W-1:0]   req_value,
  input  logic [NUM_SRC*MODE_W-1:0]    req_mode,
  output logic [NUM_SRC-1:0]           grant,
  output logic [VALUE_W-1:0]           value,
  output logic [MODE_W-1:0]            mode,
  output logic [CURSOR_W-1:0]          cursor,
  output logic                         blank,
  output logic                         busy,
  output logic [SRC_W-1:0]             active_src
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [CURSOR_W-1:0]  cursor_q, cursor_d;
  logic                 blank_q, blank_d;
  logic                 busy_q, busy_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]     active_src_q, active_src_d;

  logic                 enc_any;
  logic [SRC_W-1:0]     enc_idx;
  logic                 load;
  logic [NUM_SRC-1:0]   higher_mask;

  logic [VALUE_W-1:0]   src_value [NUM_SRC];
  logic [MODE_W-1:0]    src_mode  [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_value[i] = req_value[i*VALUE_W +: VALUE_W];
    assign src_mode[i]  = req_mode[i*MODE_W +: MODE_W];
  end

  // The encoder's pick is always the source to latch: in SHOW, any request at
  // or above the active source's priority is the lowest set bit of req.
  seg_prio_enc u_prio_enc (
    .req (req),
    .any (enc_any),
    .idx (enc_idx)
  );

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      value_q      <= '0;
      mode_q       <= '0;
      cursor_q     <= '0;
      blank_q      <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      active_src_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      value_q      <= value_d;
      mode_q       <= mode_d;
      cursor_q     <= cursor_d;
      blank_q      <= blank_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      active_src_q <= active_src_d;
    end
  end

  // Next state, shared hold/gap counter, and whether a source is latched this cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    higher_mask = src_onehot(active_src_q) - NUM_SRC'(1);
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          load    = 1'b1;
          state_d = SHOW;
          cnt_d   = HOLD_LOAD;
        end
      end
      SHOW: begin
        // A same-source request beats the timeout so a continuously updating source never blanks.
        if (|(req & higher_mask) || req[active_src_q]) begin
          load  = 1'b1;
          cnt_d = HOLD_LOAD;
        end else if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (enc_any) begin
            load    = 1'b1;
            state_d = SHOW;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the next cycle, keyed off the state being entered.
  always_comb begin
    value_d      = value_q;
    mode_d       = mode_q;
    cursor_d     = cursor_q;
    active_src_d = active_src_q;
    grant_d      = '0;
    blank_d      = (state_d == GAP);
    busy_d       = (state_d != IDLE);
    if (load) begin
      value_d      = src_value[enc_idx];
      mode_d       = src_mode[enc_idx];
      cursor_d     = CURSOR_NONE;
      grant_d      = src_onehot(enc_idx);
      active_src_d = enc_idx;
    end else if (state_d == IDLE) begin
      value_d  = base_value;
      mode_d   = base_mode;
      cursor_d = base_cursor;
    end
  end

  assign grant      = grant_q;
  assign value      = value_q;
  assign mode       = mode_q;
  assign cursor     = cursor_q;
  assign blank      = blank_q;
  assign busy       = busy_q;
  assign active_src = active_src_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - self-checking bench for seg_display_arbiter
module tb_seg_display_arbiter;

  localparam int H  = 8;
  localparam int G  = 3;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] base_value;
  logic [3:0]  base_mode;
  logic [2:0]  base_cursor;
  logic [3:0]  req;
  logic [79:0] req_value;
  logic [15:0] req_mode;
  logic [3:0]  grant;
  logic [19:0] value;
  logic [3:0]  mode;
  logic [2:0]  cursor;
  logic        blank;
  logic        busy;
  logic [1:0]  active_src;

  seg_display_arbiter #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .base_value  (base_value),
    .base_mode   (base_mode),
    .base_cursor (base_cursor),
    .req         (req),
    .req_value   (req_value),
    .req_mode    (req_mode),
    .grant       (grant),
    .value       (value),
    .mode        (mode),
    .cursor      (cursor),
    .blank       (blank),
    .busy        (busy),
    .active_src  (active_src)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline reference model: everything follows from the edge of the last
  // grant. After it the display shows for H cycles, blanks for G cycles, then
  // falls back to the base readout.
  longint      m_e;
  longint      m_g;
  logic [1:0]  m_src;
  logic [19:0] m_val;
  logic [3:0]  m_mode;
  logic [3:0]  m_grant;

  function automatic int phase_of(input longint d);
    if (d < H)     return 1;
    if (d < H + G) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_e     = 0;
    m_g     = -1000;
    m_src   = 2'd0;
    m_val   = 20'd0;
    m_mode  = 4'd0;
    m_grant = 4'd0;
  endtask

  task automatic model_edge();
    longint dp;
    int     ph;
    int     lo;
    bit     take;
    m_e++;
    dp   = m_e - 1 - m_g;
    ph   = phase_of(dp);
    take = 1'b0;
    lo   = 0;
    if (req != 4'd0) begin
      for (int i = 3; i >= 0; i--) if (req[i]) lo = i;
      if (ph == 0)      take = 1'b1;
      else if (ph == 1) take = (lo <= int'(m_src));
      else              take = (dp == longint'(H + G - 1));
    end
    m_grant = 4'd0;
    if (take) begin
      m_g     = m_e;
      m_src   = 2'(lo);
      m_val   = req_value[lo*20 +: 20];
      m_mode  = req_mode[lo*4 +: 4];
      m_grant = 4'(1) << lo;
    end
  endtask

  task automatic check_model();
    int ph;
    ph = phase_of(m_e - m_g);
    check("grant",      32'(grant),      32'(m_grant));
    check("value",      32'(value),      32'((ph == 0) ? base_value : m_val));
    check("mode",       32'(mode),       32'((ph == 0) ? base_mode : m_mode));
    check("cursor",     32'(cursor),     32'((ph == 0) ? base_cursor : 3'd7));
    check("blank",      32'(blank),      32'(ph == 2));
    check("busy",       32'(busy),       32'(ph != 0));
    check("active_src", 32'(active_src), 32'(m_src));
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
    model_edge();
    check_model();
  endtask

  task automatic set_src(input int i, input logic [19:0] v, input logic [3:0] m);
    req_value[i*20 +: 20] = v;
    req_mode[i*4 +: 4]    = m;
  endtask

  task automatic check_reset_vals();
    check("rst_grant",      32'(grant),      32'd0);
    check("rst_value",      32'(value),      32'd0);
    check("rst_mode",       32'(mode),       32'd0);
    check("rst_cursor",     32'(cursor),     32'd0);
    check("rst_blank",      32'(blank),      32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_active_src", 32'(active_src), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [19:0] src_val;
    logic [3:0]  src_mode;
    logic [3:0]  exp_grant;
    logic [19:0] exp_value;
    logic [3:0]  exp_mode;
    logic [2:0]  exp_cursor;
    logic        exp_blank;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [3:0] r, input logic [19:0] sv, input logic [3:0] sm,
                                  input logic [3:0] eg, input logic [19:0] ev, input logic [3:0] em,
                                  input logic [2:0] ec, input logic eb, input logic ebu);
    vec_t v;
    v.req = r; v.src_val = sv; v.src_mode = sm;
    v.exp_grant = eg; v.exp_value = ev; v.exp_mode = em;
    v.exp_cursor = ec; v.exp_blank = eb; v.exp_busy = ebu;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    logic [3:0] r;

    rst_n       = 1'b0;
    req         = 4'd0;
    req_value   = '0;
    req_mode    = '0;
    base_value  = 20'd12345;
    base_mode   = 4'd2;
    base_cursor = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    model_reset();

    // Base readout, then a single request from source 2 held for H, blank for G, base again.
    add_vec(4'b0000, 20'd0,   4'd0, 4'b0000, 20'd12345, 4'd2, 3'd1, 1'b0, 1'b0);
    add_vec(4'b0100, 20'd500, 4'd0, 4'b0100, 20'd500,   4'd0, 3'd7, 1'b0, 1'b1);
    for (int i = 0; i < H - 1; i++)
      add_vec(4'b0000, 20'd77, 4'd9, 4'b0000, 20'd500, 4'd0, 3'd7, 1'b0, 1'b1);
    for (int i = 0; i < G; i++)
      add_vec(4'b0000, 20'd77, 4'd9, 4'b0000, 20'd500, 4'd0, 3'd7, 1'b1, 1'b1);
    add_vec(4'b0000, 20'd77, 4'd9, 4'b0000, 20'd12345, 4'd2, 3'd1, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_src(2, vecs[i].src_val, vecs[i].src_mode);
      step(vecs[i].req);
      check($sformatf("tbl%0d_grant", i),  32'(grant),  32'(vecs[i].exp_grant));
      check($sformatf("tbl%0d_value", i),  32'(value),  32'(vecs[i].exp_value));
      check($sformatf("tbl%0d_mode", i),   32'(mode),   32'(vecs[i].exp_mode));
      check($sformatf("tbl%0d_cursor", i), 32'(cursor), 32'(vecs[i].exp_cursor));
      check($sformatf("tbl%0d_blank", i),  32'(blank),  32'(vecs[i].exp_blank));
      check($sformatf("tbl%0d_busy", i),   32'(busy),   32'(vecs[i].exp_busy));
    end

    // Simultaneous requests: lowest index wins, the waiting one lands as GAP ends.
    set_src(1, 20'd111, 4'd3);
    set_src(3, 20'd333, 4'd5);
    step(4'b1010);
    check("simul_grant", 32'(grant), 32'b0010);
    check("simul_src",   32'(active_src), 32'd1);
    found = -1;
    for (int k = 1; k <= 30; k++) begin
      step(4'b1000);
      if (grant[3]) begin
        found = k;
        break;
      end
    end
    check("late_grant_delay", 32'(found), 32'(H + G));

    // Preemption of source 3 by source 0 on the fourth SHOW cycle.
    repeat (3) step(4'b0000);
    set_src(0, 20'd999, 4'd1);
    step(4'b0001);
    check("preempt_grant", 32'(grant), 32'b0001);
    check("preempt_value", 32'(value), 32'd999);
    found = -1;
    for (int k = 1; k <= 30; k++) begin
      step(4'b0000);
      if (blank) begin
        found = k;
        break;
      end
    end
    check("preempt_hold", 32'(found), 32'(H));
    for (int k = 0; k < 30 && busy; k++) step(4'b0000);
    check("idle_again", 32'(busy), 32'd0);

    // Same-source retrigger: a grant every cycle, value follows the source.
    for (int i = 0; i < 20; i++) begin
      set_src(1, 20'(100 + i), 4'd4);
      step(4'b0010);
      check("retrig_grant", 32'(grant), 32'b0010);
      check("retrig_value", 32'(value), 32'(100 + i));
    end
    found = -1;
    for (int k = 1; k <= 30; k++) begin
      step(4'b0000);
      if (blank) begin
        found = k;
        break;
      end
    end
    check("retrig_hold", 32'(found), 32'(H));

    // Reset in the middle of GAP clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    req = 4'b0001;
    @(posedge clk);
    #1;
    check("rst_no_grant", 32'(grant), 32'd0);
    check("rst_held_busy", 32'(busy), 32'd0);
    req   = 4'b0000;
    rst_n = 1'b1;
    model_reset();
    step(4'b0000);

    // Random traffic against the timeline model, with occasional resets.
    r = 4'd0;
    for (int n = 0; n < 2000; n++) begin
      base_value  = 20'($urandom);
      base_mode   = 4'($urandom);
      base_cursor = 3'($urandom);
      for (int i = 0; i < 4; i++) set_src(i, 20'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        r = 4'd0;
        for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) r[i] = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
      end
      step(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
